intr_svc_master: RTL and testbench
==================================

# intr_svc_master

Processor-side agent for `intr_ctrl`. It drives the controller's APB-style write port to program one 4-bit priority register per peripheral from a configuration vector. It then services interrupts: it waits for `intr_valid`, holds the request for a fixed service latency, returns a one-cycle `intr_serviced` pulse, and issues a one-hot clear to the requesting peripheral. It replaces the behavioural processor model used in simulation and sits between `intr_ctrl` and the peripheral request lines.

## Interface
- `NUM_INTR`, 16: number of peripherals, legal range 1..16.
- `SVC_CYCLES`, 2: cycles spent in service before acknowledge, minimum 1.
- `pclk_i` in 1: clock; all logic is on the rising edge.
- `prst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: request to (re)program all priority registers.
- `prio_map_i` in 4*NUM_INTR: priority for peripheral i in bits [4i+3:4i]; sampled at each write, not latched.
- `paddr_o` out 8: register address, equal to the peripheral index.
- `pwdata_o` out 8: {4'b0, priority}.
- `pwrite_o` out 1: write strobe.
- `penable_o` out 1: transfer enable.
- `pready_i` in 1: transfer complete, from `intr_ctrl`.
- `intr_valid_i` in 1: controller has a pending interrupt.
- `intr_to_service_i` in 4: index of the interrupt to service.
- `intr_serviced_o` out 1: one-cycle service-done pulse to the controller.
- `intr_clear_o` out NUM_INTR: one-hot, one-cycle pulse clearing the peripheral request.
- `cfg_done_o` out 1: all NUM_INTR registers written; sticky until the next programming run.
- `busy_o` out 1: high in any state other than IDLE and SVC_WAIT.
- `svc_count_o` out 16: number of serviced interrupts, saturating.

## Operation
- **States:** IDLE, WR, WR_GAP, SVC_WAIT, SVC_BUSY, SVC_ACK, SVC_COOL.
- **Reset:** state goes to IDLE. Write index, `svc_id`, service counter and every output return to 0.
- **IDLE:**
  - `start_i`=1: go to WR with index 0 and clear `cfg_done_o`.
  - Otherwise: stay in IDLE. Interrupts are ignored.
- **WR:**
  - Outputs: `paddr_o`=index, `pwdata_o`={4'b0, `prio_map_i`[4·index+3:4·index]}, `pwrite_o`=`penable_o`=1.
  - Stay in WR until `pready_i` is sampled 1, then go to WR_GAP. There is no timeout.
- **WR_GAP:**
  - Outputs: `paddr_o`, `pwdata_o`, `pwrite_o` and `penable_o` are all 0.
  - If index=NUM_INTR-1: set `cfg_done_o` and go to SVC_WAIT.
  - Otherwise: increment index and go to WR.
- **SVC_WAIT:**
  - `intr_valid_i`=1: latch `svc_id`=`intr_to_service_i`, load the counter with SVC_CYCLES-1, go to SVC_BUSY.
  - Otherwise, `start_i`=1: clear `cfg_done_o`, reset index to 0, go to WR (reprogramming).
  - If both are 1 in the same cycle, service wins and `start_i` is dropped.
- **SVC_BUSY:** decrement the counter. When the counter is 0, go to SVC_ACK.
- **SVC_ACK:**
  - Outputs: `intr_serviced_o`=1. `intr_clear_o`[`svc_id`]=1 if `svc_id`<NUM_INTR, else all bits are 0.
  - Increment `svc_count_o`, saturating at 16'hFFFF.
  - Go to SVC_COOL.
- **SVC_COOL:** outputs idle, `intr_valid_i` is ignored for this cycle, then go to SVC_WAIT. The controller must drop or update `intr_valid_i` within this cycle.
- `start_i` is ignored in WR, WR_GAP, SVC_BUSY, SVC_ACK and SVC_COOL.
- `prio_map_i` must be held stable during programming. The block does not latch it.

## Timing
- **Outputs:** all outputs are registered. Reset values are all 0.
- **Write transfer:**
  - WR is entered 1 cycle after `start_i` is sampled.
  - Each write takes 1+N cycles in WR, where N is the number of cycles until `pready_i` is seen, followed by 1 cycle in WR_GAP.
  - With `pready_i` tied high, a full programming run takes 2·NUM_INTR cycles and `cfg_done_o` rises at cycle 2·NUM_INTR+1 after `start_i`.
- **Service latency:** with `intr_valid_i` sampled at edge T, `intr_serviced_o` and `intr_clear_o` are high for exactly the cycle after edge T+SVC_CYCLES+1. The earliest next service sample is edge T+SVC_CYCLES+3.
- **Strobe timing:** `pwrite_o` and `penable_o` rise and fall together, and are never high in consecutive writes without a gap cycle.
- **Reset mid-operation:** reset in WR deasserts the strobes on the next edge, and a partial configuration is not flagged done. Reset in SVC_BUSY or SVC_ACK suppresses or terminates the pulse, and `svc_count_o` returns to 0.

## Test plan
- **Programming, no wait states:** NUM_INTR=16, `prio_map_i`=i for slot i, `pready_i`=1, `start_i` pulsed → 16 writes to addresses 0..15 with data 0..15, `penable_o` low every other cycle, `cfg_done_o` rises 33 cycles after `start_i`.
- **Wait states:** `pready_i` delayed 3 cycles on the write to address 5 → address 5 and its data are held for 4 cycles in WR, and no other write is affected.
- **Single service:** SVC_CYCLES=2, `intr_valid_i`=1, `intr_to_service_i`=9 → `intr_serviced_o` and `intr_clear_o`=16'h0200 pulse for one cycle, 3 cycles after the sample; `svc_count_o`=1.
- **Back-to-back and collision:**
  - `intr_valid_i` held high with ids 3 then 7 → two acknowledges 5 cycles apart, clears 0x0008 then 0x0080, `svc_count_o`=2.
  - `start_i`=1 in the same cycle as `intr_valid_i`=1 → service proceeds and no write occurs.
- **Reset mid-write:** `prst_i` asserted during WR at index 4 → next edge all outputs are 0 and state is IDLE; a new `start_i` restarts at address 0.

Source files
------------

// File: rtl/intr_svc_master.sv
// Processor-side agent for intr_ctrl: programs per-peripheral priorities over the
// APB-style write port, then services interrupts with a fixed latency and one-hot clear.
module intr_svc_master #(
    parameter int NUM_INTR   = 16,
    parameter int SVC_CYCLES = 2
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic                  start_i,
    input  logic [4*NUM_INTR-1:0] prio_map_i,
    output logic [7:0]            paddr_o,
    output logic [7:0]            pwdata_o,
    output logic                  pwrite_o,
    output logic                  penable_o,
    input  logic                  pready_i,
    input  logic                  intr_valid_i,
    input  logic [3:0]            intr_to_service_i,
    output logic                  intr_serviced_o,
    output logic [NUM_INTR-1:0]   intr_clear_o,
    output logic                  cfg_done_o,
    output logic                  busy_o,
    output logic [15:0]           svc_count_o
);

    typedef enum logic [2:0] {
        IDLE, WR, WR_GAP, SVC_WAIT, SVC_BUSY, SVC_ACK, SVC_COOL
    } state_t;

    localparam int              CNTW     = (SVC_CYCLES > 1) ? $clog2(SVC_CYCLES) : 1;
    localparam logic [3:0]      IDX_LAST = 4'(NUM_INTR - 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SVC_CYCLES - 1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_idx, w_idx_nxt;
    logic [CNTW-1:0]     r_cnt, w_cnt_nxt;
    logic [3:0]          r_svc_id, w_svc_id_nxt;
    logic                r_cfg_done, w_cfg_done_nxt;
    logic                w_ack;
    logic [3:0]          w_prio;
    logic [NUM_INTR-1:0] w_clear;

    logic [7:0]          r_paddr, r_pwdata;
    logic                r_pwrite, r_penable, r_serviced, r_busy;
    logic [NUM_INTR-1:0] r_clear;
    logic [15:0]         r_svc_count;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_svc_id_nxt   = r_svc_id;
        w_cfg_done_nxt = r_cfg_done;
        w_ack          = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt    = WR;
                    w_idx_nxt      = '0;
                    w_cfg_done_nxt = 1'b0;
                end
            end
            WR: begin
                if (pready_i) w_state_nxt = WR_GAP;
            end
            WR_GAP: begin
                if (r_idx == IDX_LAST) begin
                    w_cfg_done_nxt = 1'b1;
                    w_state_nxt    = SVC_WAIT;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = WR;
                end
            end
            SVC_WAIT: begin
                // A pending interrupt takes priority over a reprogramming request
                if (intr_valid_i) begin
                    w_svc_id_nxt = intr_to_service_i;
                    w_cnt_nxt    = CNT_LOAD;
                    w_state_nxt  = SVC_BUSY;
                end else if (start_i) begin
                    w_cfg_done_nxt = 1'b0;
                    w_idx_nxt      = '0;
                    w_state_nxt    = WR;
                end
            end
            SVC_BUSY: begin
                if (r_cnt == '0) w_state_nxt = SVC_ACK;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            SVC_ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = SVC_COOL;
            end
            SVC_COOL: w_state_nxt = SVC_WAIT;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Priority nibble for the slot about to be driven; ids beyond NUM_INTR clear nothing
    always_comb begin
        w_prio  = '0;
        w_clear = '0;
        for (int unsigned k = 0; k < NUM_INTR; k++) begin
            if (w_idx_nxt == k[3:0]) w_prio = prio_map_i[4*k +: 4];
            w_clear[k] = w_ack && (r_svc_id == k[3:0]);
        end
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_svc_id    <= '0;
            r_cfg_done  <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_serviced  <= 1'b0;
            r_clear     <= '0;
            r_busy      <= 1'b0;
            r_svc_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_svc_id   <= w_svc_id_nxt;
            r_cfg_done <= w_cfg_done_nxt;
            r_pwrite   <= (w_state_nxt == WR);
            r_penable  <= (w_state_nxt == WR);
            r_paddr    <= (w_state_nxt == WR) ? {4'b0, w_idx_nxt} : '0;
            r_pwdata   <= (w_state_nxt == WR) ? {4'b0, w_prio} : '0;
            r_serviced <= w_ack;
            r_clear    <= w_clear;
            r_busy     <= !((w_state_nxt == IDLE) || (w_state_nxt == SVC_WAIT));
            if (w_ack && (r_svc_count != '1)) r_svc_count <= r_svc_count + 16'd1;
        end
    end

    assign paddr_o         = r_paddr;
    assign pwdata_o        = r_pwdata;
    assign pwrite_o        = r_pwrite;
    assign penable_o       = r_penable;
    assign intr_serviced_o = r_serviced;
    assign intr_clear_o    = r_clear;
    assign cfg_done_o      = r_cfg_done;
    assign busy_o          = r_busy;
    assign svc_count_o     = r_svc_count;

endmodule

// File: tb/tb_intr_svc_master.sv
// Directed bench for intr_svc_master: programming runs, wait states, service
// latency, back-to-back and start/valid collision, reset during a write.
module tb_intr_svc_master;

    localparam int NUM_INTR   = 16;
    localparam int SVC_CYCLES = 2;

    logic                  pclk_i = 1'b0;
    logic                  prst_i;
    logic                  start_i;
    logic [4*NUM_INTR-1:0] prio_map_i;
    logic [7:0]            paddr_o;
    logic [7:0]            pwdata_o;
    logic                  pwrite_o;
    logic                  penable_o;
    logic                  pready_i;
    logic                  intr_valid_i;
    logic [3:0]            intr_to_service_i;
    logic                  intr_serviced_o;
    logic [NUM_INTR-1:0]   intr_clear_o;
    logic                  cfg_done_o;
    logic                  busy_o;
    logic [15:0]           svc_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    intr_svc_master #(.NUM_INTR(NUM_INTR), .SVC_CYCLES(SVC_CYCLES)) dut (
        .pclk_i            (pclk_i),
        .prst_i            (prst_i),
        .start_i           (start_i),
        .prio_map_i        (prio_map_i),
        .paddr_o           (paddr_o),
        .pwdata_o          (pwdata_o),
        .pwrite_o          (pwrite_o),
        .penable_o         (penable_o),
        .pready_i          (pready_i),
        .intr_valid_i      (intr_valid_i),
        .intr_to_service_i (intr_to_service_i),
        .intr_serviced_o   (intr_serviced_o),
        .intr_clear_o      (intr_clear_o),
        .cfg_done_o        (cfg_done_o),
        .busy_o            (busy_o),
        .svc_count_o       (svc_count_o)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, " pwrite"},  32'(pwrite_o),  32'd0);
        check({tag, " penable"}, 32'(penable_o), 32'd0);
        check({tag, " paddr"},   32'(paddr_o),   32'd0);
        check({tag, " pwdata"},  32'(pwdata_o),  32'd0);
    endtask

    initial begin
        prst_i            = 1'b1;
        start_i           = 1'b0;
        pready_i          = 1'b1;
        intr_valid_i      = 1'b0;
        intr_to_service_i = 4'd0;
        for (int i = 0; i < NUM_INTR; i++) prio_map_i[4*i +: 4] = 4'(i);

        // Reset state
        tick();
        tick();
        check_idle_bus("rst");
        check("rst serviced", 32'(intr_serviced_o), 32'd0);
        check("rst clear",    32'(intr_clear_o),    32'd0);
        check("rst cfg_done", 32'(cfg_done_o),      32'd0);
        check("rst busy",     32'(busy_o),          32'd0);
        check("rst count",    32'(svc_count_o),     32'd0);
        prst_i = 1'b0;

        // Interrupts ignored in IDLE
        intr_valid_i = 1'b1;
        intr_to_service_i = 4'd2;
        tick();
        check("idle busy", 32'(busy_o), 32'd0);
        intr_valid_i = 1'b0;
        tick();
        check("idle serviced", 32'(intr_serviced_o), 32'd0);

        // Programming run, no wait states: cfg_done in cycle 33 after start
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("prog busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < NUM_INTR; i++) begin
            check($sformatf("prog%0d paddr", i),   32'(paddr_o),   32'(i));
            check($sformatf("prog%0d pwdata", i),  32'(pwdata_o),  32'(i));
            check($sformatf("prog%0d pwrite", i),  32'(pwrite_o),  32'd1);
            check($sformatf("prog%0d penable", i), 32'(penable_o), 32'd1);
            tick();
            check_idle_bus($sformatf("gap%0d", i));
            check($sformatf("gap%0d cfg_done", i), 32'(cfg_done_o), 32'd0);
            tick();
        end
        check("prog cfg_done", 32'(cfg_done_o), 32'd1);
        check("prog busy end", 32'(busy_o),     32'd0);
        check_idle_bus("wait");

        // Single service, id 9
        intr_valid_i = 1'b1;
        intr_to_service_i = 4'd9;
        tick();
        intr_valid_i = 1'b0;
        check("svc1 busy", 32'(busy_o), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("svc1 t%0d serviced", k), 32'(intr_serviced_o), 32'(k == 3));
            check($sformatf("svc1 t%0d clear", k),    32'(intr_clear_o),    (k == 3) ? 32'h0200 : 32'h0);
        end
        check("svc1 count", 32'(svc_count_o), 32'd1);
        check("svc1 busy after", 32'(busy_o), 32'd0);

        // Back-to-back: valid held, ids 3 then 7, acks five cycles apart
        intr_valid_i = 1'b1;
        intr_to_service_i = 4'd3;
        tick();
        intr_to_service_i = 4'd7;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("b2b t%0d serviced", k), 32'(intr_serviced_o), 32'(k == 3 || k == 8));
            check($sformatf("b2b t%0d clear", k), 32'(intr_clear_o),
                  (k == 3) ? 32'h0008 : ((k == 8) ? 32'h0080 : 32'h0));
            if (k == 3) check("b2b count1", 32'(svc_count_o), 32'd2);
        end
        intr_valid_i = 1'b0;
        check("b2b count2", 32'(svc_count_o), 32'd3);

        // start and valid together: service wins, no write
        tick();
        tick();
        intr_valid_i = 1'b1;
        intr_to_service_i = 4'd0;
        start_i = 1'b1;
        tick();
        intr_valid_i = 1'b0;
        start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("coll t%0d pwrite", k), 32'(pwrite_o), 32'd0);
            tick();
            if (k == 3) check("coll clear", 32'(intr_clear_o), 32'h0001);
        end
        check("coll count",    32'(svc_count_o), 32'd4);
        check("coll cfg_done", 32'(cfg_done_o),  32'd1);
        check("coll busy",     32'(busy_o),      32'd0);

        // Reprogram from SVC_WAIT with 3 wait states on address 5
        for (int i = 0; i < NUM_INTR; i++) prio_map_i[4*i +: 4] = 4'(15 - i);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("ws cfg_done clr", 32'(cfg_done_o), 32'd0);
        for (int i = 0; i < NUM_INTR; i++) begin
            check($sformatf("ws%0d paddr", i),  32'(paddr_o),  32'(i));
            check($sformatf("ws%0d pwdata", i), 32'(pwdata_o), 32'(15 - i));
            check($sformatf("ws%0d pwrite", i), 32'(pwrite_o), 32'd1);
            if (i == 5) begin
                pready_i = 1'b0;
                for (int w = 1; w <= 3; w++) begin
                    tick();
                    check($sformatf("ws5 hold%0d paddr", w),   32'(paddr_o),   32'd5);
                    check($sformatf("ws5 hold%0d pwdata", w),  32'(pwdata_o),  32'd10);
                    check($sformatf("ws5 hold%0d penable", w), 32'(penable_o), 32'd1);
                end
                pready_i = 1'b1;
            end
            tick();
            check($sformatf("ws gap%0d penable", i), 32'(penable_o), 32'd0);
            tick();
        end
        check("ws cfg_done", 32'(cfg_done_o), 32'd1);

        // Reset during the write to index 4
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (8) tick();
        check("mid paddr",  32'(paddr_o),  32'd4);
        check("mid pwrite", 32'(pwrite_o), 32'd1);
        prst_i = 1'b1;
        tick();
        prst_i = 1'b0;
        check_idle_bus("rstwr");
        check("rstwr cfg_done", 32'(cfg_done_o),  32'd0);
        check("rstwr busy",     32'(busy_o),      32'd0);
        check("rstwr count",    32'(svc_count_o), 32'd0);
        tick();
        check("rstwr idle pwrite", 32'(pwrite_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("restart paddr",  32'(paddr_o),  32'd0);
        check("restart pwdata", 32'(pwdata_o), 32'd15);
        check("restart pwrite", 32'(pwrite_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
